// File: rtl/alarm_sequencer.sv
// Alarm sequencing FSM: arming, exit/entry countdowns, sensor watch and passcode disarm.
// Drives the display block's state, seconds timer and last-entered digit.
package alarm_sequencer_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SET     = 2'd1,
    TRIGGER = 2'd2,
    ALERT   = 2'd3
  } fsm_state_t;
endpackage

module alarm_sequencer
  import alarm_sequencer_pkg::*;
#(
  parameter int         CLK_FREQ    = 50_000_000,
  parameter int         EXIT_DELAY  = 15,
  parameter int         ENTRY_DELAY = 10,
  parameter logic [3:0] PASSCODE    = 4'd7,
  parameter int         MAX_TRIES   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic       enter,
  input  logic [3:0] code,
  input  logic       sensor,
  output fsm_state_t system_state,
  output int         timer,
  output logic [0:3] current_value
);

  localparam int             PW          = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0]  PRESC_MAX   = PW'(CLK_FREQ - 1);
  // Loads are clamped so the timer can never leave the two-digit display range.
  localparam logic [6:0]     EXIT_LOAD   = 7'((EXIT_DELAY > 99) ? 99 : EXIT_DELAY);
  localparam logic [6:0]     ENTRY_LOAD  = 7'((ENTRY_DELAY > 99) ? 99 : ENTRY_DELAY);
  localparam logic [2:0]     TRIES_LIMIT = 3'(MAX_TRIES);

  fsm_state_t    state_r;
  fsm_state_t    state_nxt_s;
  logic [6:0]    timer_r;
  logic [6:0]    timer_nxt_s;
  logic [3:0]    value_r;
  logic [1:0]    tries_r;
  logic [1:0]    tries_nxt_s;
  logic [1:0]    tries_sat_s;
  logic [2:0]    tries_inc_s;
  logic [PW-1:0] presc_r;
  logic [PW-1:0] presc_nxt_s;
  logic          sensor_meta_r;
  logic          sensor_sync_r;
  logic          tick_s;
  logic          match_s;
  logic          disarm_s;
  logic          tries_hit_s;

  assign tick_s      = (presc_r == PRESC_MAX);
  assign match_s     = (code == PASSCODE);
  assign disarm_s    = enter && match_s;
  assign tries_inc_s = {1'b0, tries_r} + 3'd1;
  assign tries_hit_s = (tries_inc_s >= TRIES_LIMIT);
  assign tries_sat_s = (tries_r == 2'd3) ? 2'd3 : (tries_r + 2'd1);

  // State, countdown, tries, prescaler, digit and sensor synchroniser registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      timer_r       <= 7'd0;
      value_r       <= 4'd0;
      tries_r       <= 2'd0;
      presc_r       <= '0;
      sensor_meta_r <= 1'b0;
      sensor_sync_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      timer_r       <= timer_nxt_s;
      tries_r       <= tries_nxt_s;
      presc_r       <= presc_nxt_s;
      sensor_meta_r <= sensor;
      sensor_sync_r <= sensor_meta_r;
      if (enter) begin
        value_r <= code;
      end
    end
  end

  // Next-state decision; disarm outranks the tries limit, which outranks expiry and sensor.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (arm) state_nxt_s = SET;
        else     state_nxt_s = IDLE;
      end
      SET: begin
        if (disarm_s)                              state_nxt_s = IDLE;
        else if (timer_r == 7'd0 && sensor_sync_r) state_nxt_s = TRIGGER;
        else                                       state_nxt_s = SET;
      end
      TRIGGER: begin
        if (disarm_s)                          state_nxt_s = IDLE;
        else if (enter && tries_hit_s)         state_nxt_s = ALERT;
        else if (tick_s && timer_r <= 7'd1)    state_nxt_s = ALERT;
        else                                   state_nxt_s = TRIGGER;
      end
      ALERT: begin
        if (disarm_s) state_nxt_s = IDLE;
        else          state_nxt_s = ALERT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next timer and tries values, keyed on the current state and the chosen transition.
  always_comb begin
    timer_nxt_s = timer_r;
    tries_nxt_s = tries_r;
    case (state_r)
      IDLE: begin
        tries_nxt_s = 2'd0;
        if (arm) timer_nxt_s = EXIT_LOAD;
        else     timer_nxt_s = 7'd0;
      end
      SET: begin
        tries_nxt_s = 2'd0;
        if (state_nxt_s == IDLE)            timer_nxt_s = 7'd0;
        else if (state_nxt_s == TRIGGER)    timer_nxt_s = ENTRY_LOAD;
        else if (tick_s && timer_r != 7'd0) timer_nxt_s = timer_r - 7'd1;
        else                                timer_nxt_s = timer_r;
      end
      TRIGGER: begin
        if (state_nxt_s != TRIGGER)         timer_nxt_s = 7'd0;
        else if (tick_s && timer_r != 7'd0) timer_nxt_s = timer_r - 7'd1;
        else                                timer_nxt_s = timer_r;
        if (state_nxt_s == IDLE)            tries_nxt_s = 2'd0;
        else if (enter && !match_s)         tries_nxt_s = tries_sat_s;
        else                                tries_nxt_s = tries_r;
      end
      ALERT: begin
        timer_nxt_s = 7'd0;
        if (state_nxt_s == IDLE) tries_nxt_s = 2'd0;
        else                     tries_nxt_s = tries_r;
      end
      default: begin
        timer_nxt_s = 7'd0;
        tries_nxt_s = 2'd0;
      end
    endcase
  end

  // Prescaler restarts on every state change so the first tick lands CLK_FREQ cycles in.
  always_comb begin
    if (state_nxt_s != state_r) presc_nxt_s = '0;
    else if (tick_s)            presc_nxt_s = '0;
    else                        presc_nxt_s = presc_r + 1'b1;
  end

  assign system_state  = state_r;
  assign timer         = {25'd0, timer_r};
  assign current_value = value_r;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer: a vector table for the main sequence plus
// hand-written tries, expiry-race and asynchronous-reset sequences.
module tb_alarm_sequencer;
  import alarm_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       arm = 1'b0;
  logic       enter = 1'b0;
  logic [3:0] code = 4'd0;
  logic       sensor = 1'b0;
  fsm_state_t system_state;
  int         timer;
  logic [0:3] current_value;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       a;
    logic       e;
    logic [3:0] c;
    logic       s;
    logic [1:0] st;
    int         tm;
    logic [3:0] v;
  } vec_t;

  vec_t tbl[$];

  alarm_sequencer #(
    .CLK_FREQ   (4),
    .EXIT_DELAY (2),
    .ENTRY_DELAY(3),
    .PASSCODE   (4'd7),
    .MAX_TRIES  (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .enter        (enter),
    .code         (code),
    .sensor       (sensor),
    .system_state (system_state),
    .timer        (timer),
    .current_value(current_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] es, input int et, input logic [3:0] ev);
    logic [3:0] v;
    logic [1:0] st;
    v  = current_value;
    st = system_state;
    checks++;
    if (st !== es || timer !== et || v !== ev) begin
      errors++;
      $display("FAIL %s: got state=%0d timer=%0d value=%0d, want state=%0d timer=%0d value=%0d",
               name, st, timer, v, es, et, ev);
    end
  endtask

  task automatic step(input logic a, input logic e, input logic [3:0] c, input logic s);
    arm    = a;
    enter  = e;
    code   = c;
    sensor = s;
    @(posedge clk);
    #1;
    arm   = 1'b0;
    enter = 1'b0;
  endtask

  task automatic add(input logic a, input logic e, input logic [3:0] c, input logic s,
                     input logic [1:0] st, input int tm, input logic [3:0] v);
    vec_t r;
    r = '{a, e, c, s, st, tm, v};
    tbl.push_back(r);
  endtask

  task automatic addn(input int n, input logic [1:0] st, input int tm, input logic [3:0] v);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 4'd0, 1'b0, st, tm, v);
  endtask

  // Arm, run out the exit window, then hold the sensor until TRIGGER is entered.
  task automatic go_to_trigger(input logic [3:0] v);
    step(1'b1, 1'b0, 4'd0, 1'b0);
    check("arm_load", SET, 2, v);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
    check("exit_done", SET, 0, v);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, 1'b1);
    check("trigger_entry", TRIGGER, 3, v);
    sensor = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    #10;
    check("reset", IDLE, 0, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    add(1'b0, 1'b0, 4'd0, 1'b0, IDLE, 0, 4'd0);
    add(1'b1, 1'b0, 4'd0, 1'b0, SET, 2, 4'd0);
    add(1'b0, 1'b0, 4'd0, 1'b0, SET, 2, 4'd0);
    add(1'b0, 1'b0, 4'd0, 1'b1, SET, 2, 4'd0);
    add(1'b0, 1'b0, 4'd0, 1'b0, SET, 2, 4'd0);
    add(1'b0, 1'b0, 4'd0, 1'b0, SET, 1, 4'd0);
    addn(3, SET, 1, 4'd0);
    add(1'b0, 1'b0, 4'd0, 1'b0, SET, 0, 4'd0);
    add(1'b1, 1'b0, 4'd0, 1'b0, SET, 0, 4'd0);
    addn(3, SET, 0, 4'd0);
    add(1'b0, 1'b0, 4'd0, 1'b1, SET, 0, 4'd0);
    add(1'b0, 1'b0, 4'd0, 1'b1, SET, 0, 4'd0);
    add(1'b0, 1'b0, 4'd0, 1'b1, TRIGGER, 3, 4'd0);
    addn(3, TRIGGER, 3, 4'd0);
    addn(4, TRIGGER, 2, 4'd0);
    addn(4, TRIGGER, 1, 4'd0);
    add(1'b0, 1'b0, 4'd0, 1'b0, ALERT, 0, 4'd0);
    add(1'b0, 1'b1, 4'd5, 1'b0, ALERT, 0, 4'd5);
    add(1'b0, 1'b1, 4'd7, 1'b0, IDLE, 0, 4'd7);
    add(1'b0, 1'b1, 4'd4, 1'b0, IDLE, 0, 4'd4);
    add(1'b1, 1'b1, 4'd7, 1'b0, SET, 2, 4'd7);
    add(1'b1, 1'b0, 4'd0, 1'b0, SET, 2, 4'd7);
    add(1'b0, 1'b1, 4'd7, 1'b0, IDLE, 0, 4'd7);

    foreach (tbl[i]) begin
      step(tbl[i].a, tbl[i].e, tbl[i].c, tbl[i].s);
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].tm, tbl[i].v);
    end

    // Three wrong entries force ALERT; the right code then disarms and clears tries.
    go_to_trigger(4'd7);
    step(1'b0, 1'b1, 4'd1, 1'b0);
    check("tries_1", TRIGGER, 3, 4'd1);
    step(1'b0, 1'b1, 4'd2, 1'b0);
    check("tries_2", TRIGGER, 3, 4'd2);
    step(1'b0, 1'b1, 4'd3, 1'b0);
    check("tries_limit", ALERT, 0, 4'd3);
    step(1'b0, 1'b1, 4'd7, 1'b0);
    check("alert_disarm", IDLE, 0, 4'd7);

    go_to_trigger(4'd7);
    step(1'b0, 1'b1, 4'd1, 1'b0);
    check("tries_cleared", TRIGGER, 3, 4'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
    check("pre_expiry", TRIGGER, 1, 4'd1);
    step(1'b0, 1'b1, 4'd7, 1'b0);
    check("disarm_beats_expiry", IDLE, 0, 4'd7);

    // Asynchronous reset while in ALERT, then a normal restart.
    go_to_trigger(4'd7);
    step(1'b0, 1'b1, 4'd1, 1'b0);
    step(1'b0, 1'b1, 4'd2, 1'b0);
    step(1'b0, 1'b1, 4'd3, 1'b0);
    check("alert_before_rst", ALERT, 0, 4'd3);
    #2 rst = 1'b1;
    #1;
    check("rst_in_alert", IDLE, 0, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset mid-TRIGGER countdown, then restart.
    go_to_trigger(4'd0);
    step(1'b0, 1'b1, 4'd9, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
    check("mid_trigger", TRIGGER, 2, 4'd9);
    #2 rst = 1'b1;
    #1;
    check("rst_in_trigger", IDLE, 0, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    go_to_trigger(4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
